// File: rtl/number_digit_accumulator.sv
// rtl/number_digit_accumulator.sv - splits a JSON number token into integer/fraction/exponent segments
// Optional NUMACC_SATURATE_EN: segments clamp to all-ones on overflow and raise numOverflow.
module number_digit_accumulator #(
  parameter int SEG_W = 64,
  parameter int CNT_W = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 charIn,
  input  logic                       charValid,
  input  logic                       charLast,
  output logic                       charReady,
  output logic [2:0][SEG_W-1:0]      numberSegments,
  output logic [2:0][CNT_W-1:0]      numDigits,
  output logic                       numSign,
  output logic                       exponentSign,
  output logic                       isFloat,
  output logic                       numError,
  output logic                       numOverflow,
  output logic                       outValid,
  input  logic                       outReady
);

  typedef enum logic [3:0] {
    S_START, S_INT, S_ZERO, S_FRAC0, S_FRAC, S_ESIGN, S_EXP0, S_EXP, S_DONE
  } state_t;

  state_t state;
  state_t step_state;
  logic       is_digit, is_minus, is_plus, is_dot, is_e;
  logic       acc_en, set_err, set_float, clr_sign, clr_esign, final_err;
  logic [1:0] acc_idx;
  logic [SEG_W-1:0] cur_seg, acc_val;

  assign is_digit  = (charIn >= 8'h30) && (charIn <= 8'h39);
  assign is_minus  = (charIn == 8'h2D);
  assign is_plus   = (charIn == 8'h2B);
  assign is_dot    = (charIn == 8'h2E);
  assign is_e      = (charIn == 8'h65) || (charIn == 8'h45);
  assign charReady = !outValid;

  always_comb begin
    step_state = state;
    acc_en     = 1'b0;
    acc_idx    = 2'd0;
    set_err    = 1'b0;
    set_float  = 1'b0;
    clr_sign   = 1'b0;
    clr_esign  = 1'b0;
    case (state)
      S_START: begin
        if (is_minus) begin
          if (numSign) clr_sign = 1'b1;
          else         set_err  = 1'b1;
        end else if (is_digit) begin
          acc_en     = 1'b1;
          step_state = (charIn == 8'h30) ? S_ZERO : S_INT;
        end else set_err = 1'b1;
      end
      S_INT, S_ZERO: begin
        if (is_digit) begin
          acc_en  = 1'b1;
          set_err = (state == S_ZERO);
        end else if (is_dot) begin
          step_state = S_FRAC0;
          set_float  = 1'b1;
        end else if (is_e) begin
          step_state = S_ESIGN;
          set_float  = 1'b1;
        end else set_err = 1'b1;
      end
      S_FRAC0, S_FRAC: begin
        if (is_digit) begin
          acc_en     = 1'b1;
          acc_idx    = 2'd1;
          step_state = S_FRAC;
        end else if (is_e && state == S_FRAC) begin
          step_state = S_ESIGN;
          set_float  = 1'b1;
        end else set_err = 1'b1;
      end
      S_ESIGN: begin
        if (is_plus || is_minus) begin
          step_state = S_EXP0;
          clr_esign  = is_minus;
        end else if (is_digit) begin
          acc_en     = 1'b1;
          acc_idx    = 2'd2;
          step_state = S_EXP;
        end else set_err = 1'b1;
      end
      S_EXP0, S_EXP: begin
        if (is_digit) begin
          acc_en     = 1'b1;
          acc_idx    = 2'd2;
          step_state = S_EXP;
        end else set_err = 1'b1;
      end
      default: ;
    endcase
    final_err = (step_state == S_START) || (step_state == S_FRAC0) ||
                (step_state == S_ESIGN) || (step_state == S_EXP0);
  end

  always_comb begin
    case (acc_idx)
      2'd1:    cur_seg = numberSegments[1];
      2'd2:    cur_seg = numberSegments[2];
      default: cur_seg = numberSegments[0];
    endcase
  end

`ifdef NUMACC_SATURATE_EN
  logic [SEG_W+3:0] acc_wide;
  logic             acc_ovf;
  assign acc_wide = ({4'b0, cur_seg} * (SEG_W+4)'(10)) + (SEG_W+4)'(charIn[3:0]);
  assign acc_ovf  = |acc_wide[SEG_W+3:SEG_W];
  assign acc_val  = acc_ovf ? '1 : acc_wide[SEG_W-1:0];
`else
  assign acc_val  = (cur_seg * SEG_W'(10)) + SEG_W'(charIn[3:0]);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_START;
      numberSegments <= '0;
      numDigits      <= '0;
      numSign        <= 1'b1;
      exponentSign   <= 1'b1;
      isFloat        <= 1'b0;
      numError       <= 1'b0;
      numOverflow    <= 1'b0;
      outValid       <= 1'b0;
    end else if (outValid) begin
      // Result is frozen until the consumer takes it, then everything restarts clean.
      if (outReady) begin
        state          <= S_START;
        numberSegments <= '0;
        numDigits      <= '0;
        numSign        <= 1'b1;
        exponentSign   <= 1'b1;
        isFloat        <= 1'b0;
        numError       <= 1'b0;
        numOverflow    <= 1'b0;
        outValid       <= 1'b0;
      end
    end else if (charValid) begin
      for (int i = 0; i < 3; i++) begin
        if (acc_en && acc_idx == 2'(i)) begin
          numberSegments[i] <= acc_val;
          numDigits[i]      <= (numDigits[i] == '1) ? numDigits[i] : numDigits[i] + 1'b1;
        end
      end
`ifdef NUMACC_SATURATE_EN
      if (acc_en && acc_ovf) numOverflow <= 1'b1;
`endif
      if (set_err)   numError     <= 1'b1;
      if (set_float) isFloat      <= 1'b1;
      if (clr_sign)  numSign      <= 1'b0;
      if (clr_esign) exponentSign <= 1'b0;
      if (charLast) begin
        state    <= S_DONE;
        outValid <= 1'b1;
        if (final_err) numError <= 1'b1;
      end else begin
        state <= step_state;
      end
    end
  end

endmodule

// File: tb/tb_number_digit_accumulator.sv
// tb/tb_number_digit_accumulator.sv - self-checking bench for number_digit_accumulator
module tb_number_digit_accumulator;
  typedef logic [7:0] ch_t;
  typedef logic [211:0] bundle_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] charIn = 8'h0;
  logic charValid = 1'b0, charLast = 1'b0, outReady = 1'b0;
  logic charReady;
  logic [2:0][63:0] numberSegments;
  logic [2:0][4:0] numDigits;
  logic numSign, exponentSign, isFloat, numError, numOverflow, outValid;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  ch_t tok[$];
  ch_t int_d[$], frac_d[$], exp_d[$];
  bundle_t exp_b;

  number_digit_accumulator dut (
    .clk(clk), .rst_n(rst_n), .charIn(charIn), .charValid(charValid), .charLast(charLast),
    .charReady(charReady), .numberSegments(numberSegments), .numDigits(numDigits),
    .numSign(numSign), .exponentSign(exponentSign), .isFloat(isFloat), .numError(numError),
    .numOverflow(numOverflow), .outValid(outValid), .outReady(outReady)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bundle_t dut_bundle();
    return {numberSegments, numDigits, numSign, exponentSign, isFloat, numError, numOverflow};
  endfunction

  function automatic bundle_t mk(input logic [63:0] s0, s1, s2, input logic [4:0] c0, c1, c2,
                                 input logic sg, esg, flt, err, ovf);
    return {s2, s1, s0, c2, c1, c0, sg, esg, flt, err, ovf};
  endfunction

  localparam bundle_t RESET_B = {192'd0, 15'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  // Reference: exact decimal value of a digit string, then wrapped or clamped to 64 bits.
  task automatic seg_model(input ch_t q[$], output logic [63:0] seg, output logic [4:0] cnt,
                           output logic ov);
    logic [127:0] v;
    v = '0;
    foreach (q[i]) v = v * 128'd10 + 128'(q[i] - 8'h30);
    cnt = (q.size() > 31) ? 5'd31 : 5'(q.size());
`ifdef NUMACC_SATURATE_EN
    ov  = (v > 128'hFFFF_FFFF_FFFF_FFFF);
    seg = ov ? 64'hFFFF_FFFF_FFFF_FFFF : v[63:0];
`else
    ov  = 1'b0;
    seg = v[63:0];
`endif
  endtask

  task automatic set_tok(input string s);
    tok.delete();
    for (int i = 0; i < s.len(); i++) tok.push_back(s[i]);
  endtask

  // Called at a negedge; returns at the negedge after the final char is accepted.
  task automatic send_tok(input bit with_last);
    int n;
    for (int i = 0; i < tok.size(); i++) begin
      charIn    = tok[i];
      charValid = 1'b1;
      charLast  = with_last && (i == tok.size() - 1);
      n = 0;
      while (!charReady && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!charReady) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: charReady=%0b required 1", charReady);
      end
      @(posedge clk);
      @(negedge clk);
    end
    charValid = 1'b0;
    charLast  = 1'b0;
  endtask

  task automatic handshake();
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
  endtask

  task automatic gen_rand();
    logic [63:0] s0, s1, s2;
    logic [4:0] c0, c1, c2;
    logic o0, o1, o2, neg, eneg, has_f, has_e;
    int len, es;
    int_d.delete(); frac_d.delete(); exp_d.delete(); tok.delete();
    neg = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 4) == 0) int_d.push_back(8'h30);
    else begin
      int_d.push_back(8'h30 + 8'($urandom_range(1, 9)));
      len = ($urandom_range(0, 5) == 0) ? $urandom_range(15, 33) : $urandom_range(0, 5);
      for (int i = 0; i < len; i++) int_d.push_back(8'h30 + 8'($urandom_range(0, 9)));
    end
    has_f = 1'($urandom_range(0, 1));
    has_e = 1'($urandom_range(0, 1));
    if (has_f) begin
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) frac_d.push_back(8'h30 + 8'($urandom_range(0, 9)));
    end
    es = $urandom_range(0, 2);
    eneg = has_e && (es == 2);
    if (has_e) begin
      len = $urandom_range(1, 3);
      for (int i = 0; i < len; i++) exp_d.push_back(8'h30 + 8'($urandom_range(0, 9)));
    end
    if (neg) tok.push_back(8'h2D);
    foreach (int_d[i]) tok.push_back(int_d[i]);
    if (has_f) begin
      tok.push_back(8'h2E);
      foreach (frac_d[i]) tok.push_back(frac_d[i]);
    end
    if (has_e) begin
      tok.push_back($urandom_range(0, 1) ? 8'h65 : 8'h45);
      if (es == 1) tok.push_back(8'h2B);
      if (es == 2) tok.push_back(8'h2D);
      foreach (exp_d[i]) tok.push_back(exp_d[i]);
    end
    seg_model(int_d, s0, c0, o0);
    seg_model(frac_d, s1, c1, o1);
    seg_model(exp_d, s2, c2, o2);
    exp_b = mk(s0, s1, s2, c0, c1, c2, !neg, !eneg, has_f || has_e, 1'b0, o0 | o1 | o2);
  endtask

  task automatic test_reset();
    checks++;
    if (dut_bundle() !== RESET_B || outValid !== 1'b0 || charReady !== 1'b1) begin
      errors++;
      $display("FAIL reset: got %h v=%0b r=%0b required %h v=0 r=1", dut_bundle(), outValid, charReady, RESET_B);
    end
  endtask

  task automatic test_directed();
    string toks[3] = '{"-123", "3.1416e-5", "1.05"};
    bundle_t exps[3];
    exps[0] = mk(123, 0, 0, 3, 0, 0, 0, 1, 0, 0, 0);
    exps[1] = mk(3, 1416, 5, 1, 4, 1, 1, 0, 1, 0, 0);
    exps[2] = mk(1, 5, 0, 1, 2, 0, 1, 1, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      set_tok(toks[k]);
      send_tok(1'b1);
      checks++;
      if (outValid !== 1'b1 || dut_bundle() !== exps[k]) begin
        errors++;
        $display("FAIL directed_%s: v=%0b got %h required v=1 %h", toks[k], outValid, dut_bundle(), exps[k]);
      end
      handshake();
      checks++;
      if (charReady !== 1'b1 || outValid !== 1'b0 || dut_bundle() !== RESET_B) begin
        errors++;
        $display("FAIL release_%s: r=%0b v=%0b got %h required r=1 v=0 %h", toks[k], charReady, outValid, dut_bundle(), RESET_B);
      end
    end
  endtask

  task automatic test_errors();
    string toks[4] = '{"1.", "01", "-", "1e+"};
    for (int k = 0; k < 4; k++) begin
      set_tok(toks[k]);
      send_tok(1'b1);
      checks++;
      if (outValid !== 1'b1 || numError !== 1'b1) begin
        errors++;
        $display("FAIL error_%s: v=%0b err=%0b required v=1 err=1", toks[k], outValid, numError);
      end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    bundle_t held;
    set_tok("42");
    send_tok(1'b1);
    held = mk(42, 0, 0, 2, 0, 0, 1, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (dut_bundle() !== held || outValid !== 1'b1 || charReady !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_%0d: got %h v=%0b r=%0b required %h v=1 r=0", k, dut_bundle(), outValid, charReady, held);
      end
      @(negedge clk);
    end
    handshake();
    set_tok("7");
    send_tok(1'b1);
    checks++;
    if (dut_bundle() !== mk(7, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0) || outValid !== 1'b1) begin
      errors++;
      $display("FAIL after_backpressure: got %h v=%0b", dut_bundle(), outValid);
    end
    handshake();
  endtask

  task automatic test_overflow();
    bundle_t want;
`ifdef NUMACC_SATURATE_EN
    want = mk(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 20, 0, 0, 1, 1, 0, 0, 1);
`else
    want = mk(64'd0, 0, 0, 20, 0, 0, 1, 1, 0, 0, 0);
`endif
    set_tok("18446744073709551616");
    send_tok(1'b1);
    checks++;
    if (dut_bundle() !== want || outValid !== 1'b1) begin
      errors++;
      $display("FAIL overflow: got %h v=%0b required %h v=1", dut_bundle(), outValid, want);
    end
    handshake();
  endtask

  task automatic test_reset_mid();
    set_tok("12");
    send_tok(1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (outValid !== 1'b0 || dut_bundle() !== RESET_B) begin
        errors++;
        $display("FAIL reset_mid_%0d: v=%0b got %h required v=0 %h", k, outValid, dut_bundle(), RESET_B);
      end
      @(negedge clk);
    end
    set_tok("9");
    send_tok(1'b1);
    checks++;
    if (dut_bundle() !== mk(9, 0, 0, 1, 0, 0, 1, 1, 0, 0, 0) || outValid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_next: got %h v=%0b", dut_bundle(), outValid);
    end
    handshake();
  endtask

  task automatic test_random();
    for (int k = 0; k < 60; k++) begin
      gen_rand();
      send_tok(1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      checks++;
      if (dut_bundle() !== exp_b || outValid !== 1'b1) begin
        errors++;
        $display("FAIL random_%0d: got %h v=%0b required %h v=1", k, dut_bundle(), outValid, exp_b);
      end
      handshake();
    end
  endtask

  task automatic test_back_to_back();
    int t_prev, t_now;
    outReady = 1'b1;
    for (int k = 0; k < 8; k++) begin
      gen_rand();
      send_tok(1'b1);
      t_now = cyc;
      checks++;
      if (dut_bundle() !== exp_b || outValid !== 1'b1) begin
        errors++;
        $display("FAIL b2b_%0d: got %h v=%0b required %h v=1", k, dut_bundle(), outValid, exp_b);
      end
      if (k > 0) begin
        checks++;
        if (t_now - t_prev !== tok.size() + 1) begin
          errors++;
          $display("FAIL b2b_rate_%0d: cycles=%0d required %0d", k, t_now - t_prev, tok.size() + 1);
        end
      end
      t_prev = t_now;
    end
    @(negedge clk);
    outReady = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_directed();
    test_errors();
    test_backpressure();
    test_overflow();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
